bp_fe_bht_update_queue: RTL and testbench

Buffers branch-resolution updates from the backend and drains them into the BHT write port (w_v/idx_w/correct/pred_taken).
Sits directly upstream of the BHT.
Writes are deferred while the front end is reading the BHT, so lookups keep priority.
A starvation counter and a full condition force a drain so the BHT can never be locked out of training.

---
 rtl/bp_fe_bht_update_queue.sv | 147 ++++++++++++++
 tb/tb_bp_fe_bht_update_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_update_queue.sv
// bp_fe_bht_update_queue
// Buffers branch-resolution updates from the backend and drains them, in
// strict FIFO order, into the BHT write port. Writes yield to BHT reads,
// but a full queue or max_defer_p consecutive deferred cycles force a drain.
//
// Ports:
//   clk_i, reset_n_i                 clock, async active-low reset
//   update_v_i / update_ready_o      backend update handshake
//   update_idx_i, update_correct_i,
//   update_taken_i                   update payload
//   r_v_i                            BHT read active this cycle
//   flush_i                          discard all pending updates
//   w_v_o, idx_w_o, correct_o,
//   pred_taken_o                     BHT write port (always accepted)
//   pending_o                        queue non-empty
//
// Optional feature: define BP_FE_BHT_UPDQ_BYPASS_EN to let an update that
// arrives on an empty queue with no read in progress write the BHT in the
// same cycle without being stored.
module bp_fe_bht_update_queue #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned els_p           = 4,
    parameter int unsigned max_defer_p     = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       update_v_i,
    output logic                       update_ready_o,
    input  logic [bht_idx_width_p-1:0] update_idx_i,
    input  logic                       update_correct_i,
    input  logic                       update_taken_i,
    input  logic                       r_v_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic                       pred_taken_o,
    output logic                       pending_o
);

    localparam int unsigned PTR_W   = $clog2(els_p);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned DEFER_W = $clog2(max_defer_p + 1);

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       correct;
        logic                       taken;
    } entry_t;

    entry_t             mem_q [els_p];
    entry_t             mem_d [els_p];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEFER_W-1:0] defer_q, defer_d;

    logic   empty, full, force_drain, ready, bypass, enq, deq;
    entry_t head, incoming;

    // Queue status and handshake; ready is held low while in reset.
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CNT_W'(els_p));
        force_drain = full | (defer_q == DEFER_W'(max_defer_p));
        ready       = reset_n_i & ~full & ~flush_i;
        incoming    = '{idx: update_idx_i, correct: update_correct_i, taken: update_taken_i};
        head        = mem_q[rd_ptr_q];
`ifdef BP_FE_BHT_UPDQ_BYPASS_EN
        bypass      = reset_n_i & empty & update_v_i & ~r_v_i & ~flush_i;
`else
        bypass      = 1'b0;
`endif
        deq         = ~empty & ~flush_i & (~r_v_i | force_drain);
        enq         = update_v_i & ready & ~bypass;
    end

    // BHT write port: head entry on a drain, the live update on a bypass, else zero.
    always_comb begin
        w_v_o        = deq | bypass;
        idx_w_o      = '0;
        correct_o    = 1'b0;
        pred_taken_o = 1'b0;
        if (deq) begin
            idx_w_o      = head.idx;
            correct_o    = head.correct;
            pred_taken_o = head.taken;
        end else if (bypass) begin
            idx_w_o      = incoming.idx;
            correct_o    = incoming.correct;
            pred_taken_o = incoming.taken;
        end
        update_ready_o = ready;
        pending_o      = ~empty;
    end

    // Next-state: pointers, occupancy, storage and the starvation counter.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        defer_d  = defer_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            defer_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = incoming;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
            // Count only cycles where a read actually held off a pending write.
            if (empty || deq) begin
                defer_d = '0;
            end else if (r_v_i && (defer_q != DEFER_W'(max_defer_p))) begin
                defer_d = defer_q + DEFER_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            defer_q  <= '0;
            for (int i = 0; i < int'(els_p); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            defer_q  <= defer_d;
            for (int i = 0; i < int'(els_p); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Directed bench for bp_fe_bht_update_queue (default parameters: idx width 9,
// depth 4, max_defer 3). Inputs change 1 time unit after a rising edge and
// outputs are sampled a few units later, well before the next edge.
module tb_bp_fe_bht_update_queue;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       update_v_i;
    logic       update_ready_o;
    logic [8:0] update_idx_i;
    logic       update_correct_i;
    logic       update_taken_i;
    logic       r_v_i;
    logic       flush_i;
    logic       w_v_o;
    logic [8:0] idx_w_o;
    logic       correct_o;
    logic       pred_taken_o;
    logic       pending_o;

    int n_checks = 0;
    int n_errors = 0;

    bp_fe_bht_update_queue #(
        .bht_idx_width_p(9),
        .els_p          (4),
        .max_defer_p    (3)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .update_v_i      (update_v_i),
        .update_ready_o  (update_ready_o),
        .update_idx_i    (update_idx_i),
        .update_correct_i(update_correct_i),
        .update_taken_i  (update_taken_i),
        .r_v_i           (r_v_i),
        .flush_i         (flush_i),
        .w_v_o           (w_v_o),
        .idx_w_o         (idx_w_o),
        .correct_o       (correct_o),
        .pred_taken_o    (pred_taken_o),
        .pending_o       (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] idx, input logic c, input logic t);
        update_v_i       = v;
        update_idx_i     = idx;
        update_correct_i = c;
        update_taken_i   = t;
    endtask

    logic [8:0] seen [4];
    int         got;

    initial begin
        reset_n_i = 1'b0;
        r_v_i     = 1'b0;
        flush_i   = 1'b0;
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #3;
        check("rst_w_v",     32'(w_v_o),          32'd0);
        check("rst_pending", 32'(pending_o),      32'd0);
        check("rst_ready",   32'(update_ready_o), 32'd0);
        check("rst_idx",     32'(idx_w_o),        32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();

        // 1/6: single update, no read in progress
        drive(1'b1, 9'h05, 1'b1, 1'b1);
        #2;
        check("t1_ready", 32'(update_ready_o), 32'd1);
`ifdef BP_FE_BHT_UPDQ_BYPASS_EN
        check("t1_bypass_w_v", 32'(w_v_o),   32'd1);
        check("t1_bypass_idx", 32'(idx_w_o), 32'h05);
        tick();
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #2;
        check("t1_bypass_nostore", 32'(pending_o), 32'd0);
        check("t1_bypass_no_w",    32'(w_v_o),     32'd0);
`else
        check("t1_same_cycle_w_v", 32'(w_v_o), 32'd0);
        tick();
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #2;
        check("t1_w_v",     32'(w_v_o),        32'd1);
        check("t1_idx",     32'(idx_w_o),      32'h05);
        check("t1_correct", 32'(correct_o),    32'd1);
        check("t1_taken",   32'(pred_taken_o), 32'd1);
`endif
        tick();
        #2;
        check("t1_pending_after", 32'(pending_o), 32'd0);
        check("t1_w_v_after",     32'(w_v_o),     32'd0);

        // 6 (second vector): idx 0x1A with correct=0, taken=1
        drive(1'b1, 9'h1A, 1'b0, 1'b1);
        #2;
`ifdef BP_FE_BHT_UPDQ_BYPASS_EN
        check("t6_w_v_0lat", 32'(w_v_o),   32'd1);
        check("t6_idx_0lat", 32'(idx_w_o), 32'h1A);
        tick();
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #2;
        check("t6_count0", 32'(pending_o), 32'd0);
`else
        check("t6_w_v_0lat", 32'(w_v_o), 32'd0);
        tick();
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #2;
        check("t6_w_v_1lat",   32'(w_v_o),        32'd1);
        check("t6_idx_1lat",   32'(idx_w_o),      32'h1A);
        check("t6_correct",    32'(correct_o),    32'd0);
        check("t6_taken",      32'(pred_taken_o), 32'd1);
`endif
        tick();

        // 2: fill under a continuous read; full forces a drain; FIFO order
        r_v_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 9'(i), 1'b0, 1'b0);
            #2;
            check("t2_ready_fill", 32'(update_ready_o), 32'd1);
            check("t2_no_w_fill",  32'(w_v_o),          32'd0);
            tick();
        end
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #2;
        check("t2_full_ready", 32'(update_ready_o), 32'd0);
        check("t2_force_w_v",  32'(w_v_o),          32'd1);
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (w_v_o) begin
                seen[got] = idx_w_o;
                got++;
            end
            tick();
            #2;
        end
        check("t2_drain_count", 32'(got), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_order", 32'(seen[k]), 32'(k + 1));
        end
        r_v_i = 1'b0;
        tick();

        // 3: starvation counter forces a write on the 4th deferred cycle
        r_v_i = 1'b1;
        drive(1'b1, 9'h07, 1'b1, 1'b0);
        tick();
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #2;
        for (int k = 0; k < 3; k++) begin
            check("t3_defer_hold", 32'(w_v_o), 32'd0);
            tick();
            #2;
        end
        check("t3_forced_w_v", 32'(w_v_o),   32'd1);
        check("t3_forced_idx", 32'(idx_w_o), 32'h07);
        tick();
        r_v_i = 1'b0;
        #2;
        check("t3_empty", 32'(pending_o), 32'd0);
        tick();

        // 4: flush with 3 queued and a concurrent update
        r_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9'(16 + i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 9'h1F, 1'b1, 1'b1);
        flush_i = 1'b1;
        #2;
        check("t4_flush_w_v",   32'(w_v_o),          32'd0);
        check("t4_flush_ready", 32'(update_ready_o), 32'd0);
        tick();
        flush_i = 1'b0;
        r_v_i   = 1'b0;
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #2;
        check("t4_pending", 32'(pending_o), 32'd0);
        check("t4_no_w_0",  32'(w_v_o),     32'd0);
        tick();
        #2;
        check("t4_no_w_1", 32'(w_v_o), 32'd0);
        tick();

        // 5: async reset in the middle of a drain
        r_v_i = 1'b1;
        drive(1'b1, 9'h21, 1'b1, 1'b1);
        tick();
        drive(1'b1, 9'h22, 1'b0, 1'b0);
        tick();
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        r_v_i = 1'b0;
        #2;
        check("t5_w_v_pre",   32'(w_v_o),     32'd1);
        check("t5_idx_pre",   32'(idx_w_o),   32'h21);
        check("t5_pend_pre",  32'(pending_o), 32'd1);
        #1;
        reset_n_i = 1'b0;
        #1;
        check("t5_rst_w_v",   32'(w_v_o),          32'd0);
        check("t5_rst_pend",  32'(pending_o),      32'd0);
        check("t5_rst_ready", 32'(update_ready_o), 32'd0);
        #1;
        reset_n_i = 1'b1;
        #1;
        check("t5_rel_ready", 32'(update_ready_o), 32'd1);
        check("t5_rel_pend",  32'(pending_o),      32'd0);
        tick();
        #2;
        check("t5_post_w_v",  32'(w_v_o),     32'd0);
        check("t5_post_pend", 32'(pending_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
